inventory_tracker: RTL and testbench
====================================

Name: inventory_tracker

Overview:
- Upstream stage of the quoting path. Takes trade-fill events from the execution interface and keeps the signed net inventory position.
- Publishes that position as the registered 64-bit `inventory_state` consumed by `order_quantity`.
- Saturating arithmetic; limit and overflow flags.
- Synchronous flush (clear) for end-of-session or risk reset.

Parameters:
- QTY_W, 32, width of the fill quantity field (unsigned).
- POS_LIMIT, 64'sd10000, magnitude threshold for the long/short limit flags (must be > 0).

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_fill_valid  in  1  fill event present.
- o_fill_ready  out  1  tracker can accept a fill this cycle.
- i_fill_side  in  1  0 = buy (+qty), 1 = sell (-qty).
- i_fill_qty  in  QTY_W  fill quantity, unsigned.
- i_clear  in  1  flush request, level-sampled.
- o_inventory_state  out  64 signed  current net position.
- o_inventory_valid  out  1  one-cycle pulse when o_inventory_state was updated.
- o_long_limit  out  1  o_inventory_state >= POS_LIMIT.
- o_short_limit  out  1  o_inventory_state <= -POS_LIMIT.
- o_sat_err  out  1  sticky; set when an update saturated.
- o_fill_count  out  32  fills applied since reset/clear; wraps mod 2^32.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - o_inventory_state = 0; o_inventory_valid = 0.
  - o_long_limit = 0; o_short_limit = 0; o_sat_err = 0.
  - o_fill_count = 0; stage register empty; FSM = S_RUN.
  - o_fill_ready = 0 while reset is asserted.
  - Reset mid-operation discards any staged fill; no valid pulse follows.
- FSM states:
  - S_RUN: o_fill_ready = 1. i_clear high → S_CLEAR.
  - S_CLEAR: lasts exactly one cycle with o_fill_ready = 0, then returns to S_RUN.
  - If i_clear is still high on return to S_RUN, the FSM re-enters S_CLEAR next cycle.
- Handshake: a fill is accepted on a rising edge where i_fill_valid && o_fill_ready. No accept occurs in the cycle i_clear is high, because the transition is evaluated first and o_fill_ready is combinationally gated by i_clear.
- Pipeline:
  - Accept at edge N captures side/qty into the stage register.
  - Edge N+1 writes the new inventory, flags, and count.
  - o_inventory_valid is high for the cycle following edge N+1.
  - Back-to-back accepts give one update per cycle, throughput 1 fill/cycle.
- Arithmetic:
  - qty is zero-extended to 65 bits signed; the 65-bit sum/difference is formed with inventory.
  - Result > 2^63-1 clamps to 2^63-1; result < -2^63 clamps to -2^63.
  - Either clamp sets o_sat_err.
- Zero-quantity fill: accepted, counted, valid pulse issued, inventory unchanged.
- Flags: o_long_limit / o_short_limit are registered from the newly written value, in the same edge as inventory.
- Clear (on entering S_CLEAR edge):
  - Inventory, flags, o_sat_err and o_fill_count go to 0.
  - A fill held in the stage register is discarded (clear wins over the simultaneous update).
  - o_inventory_valid pulses once to publish the zero.
- o_inventory_state holds its value between updates; downstream may sample it at any time.

Decomposition:
- Package `hft_pkg`:
  - side_e enum (SIDE_BUY = 0, SIDE_SELL = 1).
  - inv_state_e enum (S_RUN, S_CLEAR).
  - INV_MAX / INV_MIN 64-bit constants.
  - inventory_t typedef (logic signed [63:0]), shared with `order_quantity`.
- One combinational sub-module, `sat_add64`: signed 64-bit base + signed 65-bit delta → clamped 64-bit result plus overflow flag. Reused by future P&L accumulators.

Test Plan:
- Reset, then buy 150 at cycle 0 and sell 40 at cycle 1:
  - o_inventory_state = 150 with valid in cycle 2.
  - o_inventory_state = 110 with valid in cycle 3.
  - o_fill_count = 2.
- Buy 10000 from 0 → o_long_limit = 1; sell 20000 → state = -10000, o_short_limit = 1, o_long_limit = 0.
- Inventory preloaded to 2^63-100 via fills, then buy 500 → state = 2^63-1, o_sat_err = 1 and stays set through a following sell 1 (state 2^63-2).
- Fill accepted at edge N and i_clear high in cycle N+1:
  - Staged fill dropped.
  - State = 0, count = 0, single valid pulse.
  - o_fill_ready low during the i_clear cycle.
- Continuous i_fill_valid with alternating buy 1 / sell 1 for 64 cycles → one valid pulse per cycle, final state 0, o_fill_count = 64.
- i_rst_n low for one cycle while a fill is staged with inventory = 500 → all outputs zero next cycle, no valid pulse for the staged fill.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types and constants for the quoting path (inventory tracker,
// order quantity, future P&L accumulators).
package hft_pkg;

  // Fill direction as presented by the execution interface.
  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_e;

  // Inventory tracker control states.
  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } inv_state_e;

  // Signed net position word, shared with order_quantity.
  typedef logic signed [63:0] inventory_t;

  localparam inventory_t INV_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam inventory_t INV_MIN = 64'sh8000_0000_0000_0000;

endpackage

// File: rtl/inventory_tracker_if.sv
// Fill handshake between the execution interface (master) and the
// inventory tracker (slave).
interface inventory_tracker_if #(
  parameter int QTY_W = 32
);
  logic             i_fill_valid;
  logic             o_fill_ready;
  logic             i_fill_side;
  logic [QTY_W-1:0] i_fill_qty;

  modport master (
    output i_fill_valid,
    output i_fill_side,
    output i_fill_qty,
    input  o_fill_ready
  );

  modport slave (
    input  i_fill_valid,
    input  i_fill_side,
    input  i_fill_qty,
    output o_fill_ready
  );
endinterface

// File: rtl/sat_add64.sv
// Saturating add of a signed 64-bit base and a signed 65-bit delta.
// The sum is formed at 66 bits so any 65-bit delta fits without wrap;
// out-of-range results clamp to the 64-bit signed limits.
module sat_add64
  import hft_pkg::*;
(
  input  inventory_t         base_i,
  input  logic signed [64:0] delta_i,
  output inventory_t         sum_o,
  output logic               ovf_o
);

  logic signed [65:0] wide_s;

  // Wide sum, then clamp when the top three bits disagree (out of 64-bit range).
  always_comb begin
    wide_s = $signed({{2{base_i[63]}}, base_i}) + $signed({delta_i[64], delta_i});
    if ((wide_s[65:63] == 3'b000) || (wide_s[65:63] == 3'b111)) begin
      sum_o = wide_s[63:0];
      ovf_o = 1'b0;
    end else if (wide_s[65] == 1'b0) begin
      sum_o = INV_MAX;
      ovf_o = 1'b1;
    end else begin
      sum_o = INV_MIN;
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/inventory_tracker.sv
// Net inventory tracker: accepts fills into a one-deep stage register,
// applies them with saturating arithmetic on the next edge, and publishes
// the registered position plus limit/saturation flags and a fill count.
module inventory_tracker
  import hft_pkg::*;
#(
  parameter int         QTY_W     = 32,
  parameter inventory_t POS_LIMIT = 64'sd10000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  inventory_tracker_if.slave  fill,
  input  logic                i_clear,
  output inventory_t          o_inventory_state,
  output logic                o_inventory_valid,
  output logic                o_long_limit,
  output logic                o_short_limit,
  output logic                o_sat_err,
  output logic [31:0]         o_fill_count
);

  inv_state_e       state_q;
  logic             stage_vld_q;
  side_e            stage_side_q;
  logic [QTY_W-1:0] stage_qty_q;
  inventory_t       inv_q;
  logic             valid_q;
  logic             long_q;
  logic             short_q;
  logic             sat_q;
  logic [31:0]      count_q;

  logic signed [64:0] qty_ext_s;
  logic signed [64:0] delta_s;
  inventory_t         inv_d;
  logic               ovf_s;
  logic               long_d;
  logic               short_d;
  logic               accept_s;

  // Clear is gated in combinationally so no fill is taken on the flush edge.
  assign fill.o_fill_ready = i_rst_n & (state_q == S_RUN) & ~i_clear;
  assign accept_s          = fill.i_fill_valid & fill.o_fill_ready;

  // Signed delta from the staged fill: buy adds, sell subtracts.
  always_comb begin
    qty_ext_s = $signed(65'(stage_qty_q));
    if (stage_side_q == SIDE_SELL) begin
      delta_s = -qty_ext_s;
    end else begin
      delta_s = qty_ext_s;
    end
  end

  sat_add64 u_sat_add64 (
    .base_i  (inv_q),
    .delta_i (delta_s),
    .sum_o   (inv_d),
    .ovf_o   (ovf_s)
  );

  // Limit flags evaluated on the value about to be written.
  always_comb begin
    long_d  = (inv_d >= POS_LIMIT);
    short_d = (inv_d <= -POS_LIMIT);
  end

  // Control FSM, stage register and all published outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_RUN;
      stage_vld_q  <= 1'b0;
      stage_side_q <= SIDE_BUY;
      stage_qty_q  <= '0;
      inv_q        <= 64'sd0;
      valid_q      <= 1'b0;
      long_q       <= 1'b0;
      short_q      <= 1'b0;
      sat_q        <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (i_clear) begin
            // Flush wins over any staged fill; publish the zero once.
            state_q     <= S_CLEAR;
            stage_vld_q <= 1'b0;
            inv_q       <= 64'sd0;
            long_q      <= 1'b0;
            short_q     <= 1'b0;
            sat_q       <= 1'b0;
            count_q     <= 32'd0;
            valid_q     <= 1'b1;
          end else begin
            stage_vld_q <= accept_s;
            if (accept_s) begin
              stage_side_q <= side_e'(fill.i_fill_side);
              stage_qty_q  <= fill.i_fill_qty;
            end
            if (stage_vld_q) begin
              inv_q   <= inv_d;
              long_q  <= long_d;
              short_q <= short_d;
              sat_q   <= sat_q | ovf_s;
              count_q <= count_q + 32'd1;
              valid_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          state_q     <= S_RUN;
          stage_vld_q <= 1'b0;
        end
        default: begin
          state_q     <= S_RUN;
          stage_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_inventory_state = inv_q;
  assign o_inventory_valid = valid_q;
  assign o_long_limit      = long_q;
  assign o_short_limit     = short_q;
  assign o_sat_err         = sat_q;
  assign o_fill_count      = count_q;

endmodule

// File: tb/tb_inventory_tracker.sv
// Directed bench for inventory_tracker: a vector table for the single-fill
// paths plus hand-written sequences for clear, streaming and reset corners.
// The DUT runs with a 64-bit quantity field so saturation is reachable.
module tb_inventory_tracker;
  import hft_pkg::*;

  localparam int QTY_W = 64;

  logic        clk;
  logic        rst_n;
  logic        clear;
  inventory_t  state;
  logic        inv_valid;
  logic        long_lim;
  logic        short_lim;
  logic        sat_err;
  logic [31:0] fill_count;

  int n_chk;
  int n_fail;

  inventory_tracker_if #(.QTY_W(QTY_W)) fif ();

  inventory_tracker #(
    .QTY_W     (QTY_W),
    .POS_LIMIT (64'sd10000)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .fill              (fif),
    .i_clear           (clear),
    .o_inventory_state (state),
    .o_inventory_valid (inv_valid),
    .o_long_limit      (long_lim),
    .o_short_limit     (short_lim),
    .o_sat_err         (sat_err),
    .o_fill_count      (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        vld;
    logic        side;
    logic [63:0] qty;
    logic [63:0] st;
    logic        v;
    logic        lg;
    logic        sh;
    logic        sat;
    logic [31:0] cnt;
    logic        rdy;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic clr, input logic vld, input logic side,
                              input logic [63:0] qty, input logic [63:0] st,
                              input logic v, input logic lg, input logic sh,
                              input logic sat, input logic [31:0] cnt, input logic rdy);
    vec_t r;
    r.clr = clr; r.vld = vld; r.side = side; r.qty = qty; r.st = st; r.v = v;
    r.lg = lg; r.sh = sh; r.sat = sat; r.cnt = cnt; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic vld, input logic side, input logic [63:0] qty);
    clear            = clr;
    fif.i_fill_valid = vld;
    fif.i_fill_side  = side;
    fif.i_fill_qty   = qty;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] P62    = 64'h4000_0000_0000_0000;
  localparam logic [63:0] P62M   = 64'h3FFF_FFFF_FFFF_FF9C;
  localparam logic [63:0] P63M   = 64'h7FFF_FFFF_FFFF_FF9C;
  localparam logic [63:0] P63M1  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P63M2  = 64'h7FFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] NEGMIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG10K = 64'hFFFF_FFFF_FFFF_D8F0;

  initial begin
    int pulses;
    n_chk  = 0;
    n_fail = 0;

    //             clr   vld   side  qty        st      v     lg    sh    sat   cnt     rdy
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 64'd150,   64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 64'd40,    64'd150,1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 64'd0,     64'd110,1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 64'd0,     64'd110,1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 64'd0,     64'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 64'd0,     64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 64'd10000, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 64'd0,     64'd10000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 64'd20000, 64'd10000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 64'd0,     NEG10K, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 64'd0,     NEG10K, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 64'd0,     64'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 64'd0,     64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, P62,       64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, P62M,      P62,    1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 64'd500,   P63M,   1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 64'd1,     P63M1,  1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 1'b1);
    tbl[17] = mk(1'b0, 1'b1, 1'b1, ALL1,      P63M2,  1'b1, 1'b1, 1'b0, 1'b1, 32'd4, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 64'd0,     NEGMIN, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 1'b1);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 64'd0,     NEGMIN, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5, 1'b1);
    tbl[20] = mk(1'b1, 1'b0, 1'b0, 64'd0,     64'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 64'd0,     64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    tick();
    tick();
    chk("rst_state", state, 64'd0);
    chk("rst_valid", {63'd0, inv_valid}, 64'd0);
    chk("rst_flags", {61'd0, long_lim, short_lim, sat_err}, 64'd0);
    chk("rst_count", {32'd0, fill_count}, 64'd0);
    chk("rst_ready", {63'd0, fif.o_fill_ready}, 64'd0);
    rst_n = 1'b1;
    #1;

    // Table-driven single-fill paths
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].clr, tbl[i].vld, tbl[i].side, tbl[i].qty);
      tick();
      chk($sformatf("row%0d_state", i), state, tbl[i].st);
      chk($sformatf("row%0d_valid", i), {63'd0, inv_valid}, {63'd0, tbl[i].v});
      chk($sformatf("row%0d_long", i), {63'd0, long_lim}, {63'd0, tbl[i].lg});
      chk($sformatf("row%0d_short", i), {63'd0, short_lim}, {63'd0, tbl[i].sh});
      chk($sformatf("row%0d_sat", i), {63'd0, sat_err}, {63'd0, tbl[i].sat});
      chk($sformatf("row%0d_count", i), {32'd0, fill_count}, {32'd0, tbl[i].cnt});
      chk($sformatf("row%0d_ready", i), {63'd0, fif.o_fill_ready}, {63'd0, tbl[i].rdy});
    end

    // Clear arriving the cycle after an accept drops the staged fill
    drive(1'b0, 1'b1, 1'b0, 64'd300);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    tick();
    chk("clr_pre_state", state, 64'd300);
    drive(1'b0, 1'b1, 1'b0, 64'd7);
    tick();
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    #1;
    chk("clr_ready_low", {63'd0, fif.o_fill_ready}, 64'd0);
    tick();
    chk("clr_state", state, 64'd0);
    chk("clr_count", {32'd0, fill_count}, 64'd0);
    chk("clr_valid", {63'd0, inv_valid}, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(inv_valid);
    end
    chk("clr_no_late_pulse", 64'(pulses), 64'd0);
    chk("clr_post_state", state, 64'd0);

    // Streaming alternating buy 1 / sell 1 for 64 cycles
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b1, (i % 2 == 1), 64'd1);
      tick();
      pulses += int'(inv_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      pulses += int'(inv_valid);
    end
    chk("stream_pulses", 64'(pulses), 64'd64);
    chk("stream_state", state, 64'd0);
    chk("stream_count", {32'd0, fill_count}, 64'd64);

    // Reset while a fill is staged
    drive(1'b0, 1'b1, 1'b0, 64'd500);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    tick();
    chk("mrst_pre_state", state, 64'd500);
    drive(1'b0, 1'b1, 1'b0, 64'd9);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    rst_n = 1'b0;
    tick();
    chk("mrst_state", state, 64'd0);
    chk("mrst_valid", {63'd0, inv_valid}, 64'd0);
    chk("mrst_count", {32'd0, fill_count}, 64'd0);
    chk("mrst_flags", {61'd0, long_lim, short_lim, sat_err}, 64'd0);
    chk("mrst_ready", {63'd0, fif.o_fill_ready}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("mrst_post_valid", {63'd0, inv_valid}, 64'd0);
    chk("mrst_post_state", state, 64'd0);
    chk("mrst_post_ready", {63'd0, fif.o_fill_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
